// File: rtl/frog_pkg.sv
// Shared types and key-index constants for the frog move controller.
package frog_pkg;

    typedef enum logic {IDLE, HOLD} move_state_t;

    localparam int unsigned NUM_KEYS = 4;
    localparam int unsigned KEY_L    = 3;
    localparam int unsigned KEY_R    = 2;
    localparam int unsigned KEY_F    = 1;
    localparam int unsigned KEY_B    = 0;

endpackage

// File: rtl/key_debounce.sv
// One push-button: two-flop synchronizer plus a hold-time debounce counter.
// level is the accepted, active-high pressed state of the key.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic level
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

    logic          sync1;
    logic          sync2;
    logic          key_s;
    logic [CW-1:0] cnt;

    assign key_s = ~sync2;

    // The counter restarts whenever the synchronized level matches the accepted
    // one, so only an uninterrupted run of DEBOUNCE_CYCLES disagreements flips it.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            if (key_s == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= key_s;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/frog_move_ctrl.sv
// Turns the four raw board keys into clean, mutually exclusive one-cycle move
// strobes and keeps a saturating per-round move counter.
module frog_move_ctrl
    import frog_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       key_n,
    input  logic             enable,
    input  logic             round_win,
    output logic             L,
    output logic             R,
    output logic             F,
    output logic             B,
    output logic [CNT_W-1:0] move_count
);

    logic [NUM_KEYS-1:0] db;
    logic [NUM_KEYS-1:0] db_q;
    logic [NUM_KEYS-1:0] rise;
    logic                clean_press;
    logic                accept;
    move_state_t         state;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .key_n (key_n[i]),
            .level (db[i])
        );
    end

    // A press is clean only if it is the sole key down: one new rise and no
    // other debounced level already high.
    always_comb begin
        rise        = db & ~db_q;
        clean_press = $onehot(rise) && (db == rise);
        accept      = (state == IDLE) && clean_press && enable;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            db_q  <= '0;
            state <= IDLE;
            L     <= 1'b0;
            R     <= 1'b0;
            F     <= 1'b0;
            B     <= 1'b0;
        end else begin
            db_q <= db;
            L    <= 1'b0;
            R    <= 1'b0;
            F    <= 1'b0;
            B    <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise != '0) begin
                        state <= HOLD;
                        if (accept) begin
                            L <= rise[KEY_L];
                            R <= rise[KEY_R];
                            F <= rise[KEY_F];
                            B <= rise[KEY_B];
                        end
                    end
                end
                HOLD: begin
                    if (db == '0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            move_count <= '0;
        end else if (round_win) begin
            move_count <= '0;
        end else if (accept && (move_count != '1)) begin
            move_count <= move_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_frog_move_ctrl.sv
// Directed bench for frog_move_ctrl: a vector table of single presses plus
// hand-written bounce, overlap, saturation and reset-mid-press sequences.
module tb_frog_move_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] key_n;
    logic       enable;
    logic       round_win;

    logic       l8, r8, f8, b8;
    logic [7:0] count8;
    logic       l2, r2, f2, b2;
    logic [1:0] count2;

    frog_move_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut8 (
        .clk        (clk),
        .reset      (reset),
        .key_n      (key_n),
        .enable     (enable),
        .round_win  (round_win),
        .L          (l8),
        .R          (r8),
        .F          (f8),
        .B          (b8),
        .move_count (count8)
    );

    frog_move_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(2)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .key_n      (key_n),
        .enable     (enable),
        .round_win  (round_win),
        .L          (l2),
        .R          (r2),
        .F          (f2),
        .B          (b2),
        .move_count (count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] strb;
    assign strb = {l8, r8, f8, b8};

    int checks = 0;
    int errors = 0;
    int scnt[4];
    int first_edge;
    int edge_no;

    typedef struct {
        string      name;
        logic [3:0] key;
        logic       en;
        logic [3:0] exp_mask;
        int         exp_count;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic clear_mon();
        for (int i = 0; i < 4; i++) scnt[i] = 0;
        first_edge = -1;
        edge_no    = 0;
    endtask

    // Advance n clock edges; sample #1 after each edge, tally strobes and
    // check that no two strobes are ever high together.
    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            edge_no++;
            check("strobe_exclusive", ($countones(strb) > 1) ? 1 : 0, 0);
            for (int i = 0; i < 4; i++) begin
                if (strb[i]) begin
                    scnt[i]++;
                    if (first_edge < 0) first_edge = edge_no;
                end
            end
        end
    endtask

    function automatic int total_strobes();
        return scnt[0] + scnt[1] + scnt[2] + scnt[3];
    endfunction

    task automatic release_all(input string name, input int exp_count);
        key_n  = 4'hF;
        enable = 1'b1;
        clear_mon();
        cycles(12);
        check({name, "_release_quiet"}, total_strobes(), 0);
        check({name, "_release_count"}, int'(count8), exp_count);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycles(3);
        reset = 1'b0;
    endtask

    initial begin
        int exp8;

        vecs[0] = '{"left",          4'b0111, 1'b1, 4'b1000, 1};
        vecs[1] = '{"fwd_back_same", 4'b1100, 1'b1, 4'b0000, 1};
        vecs[2] = '{"back",          4'b1110, 1'b1, 4'b0001, 2};
        vecs[3] = '{"right_frozen",  4'b1011, 1'b0, 4'b0000, 2};
        vecs[4] = '{"right",         4'b1011, 1'b1, 4'b0100, 3};
        vecs[5] = '{"forward",       4'b1101, 1'b1, 4'b0010, 4};

        key_n     = 4'hF;
        enable    = 1'b1;
        round_win = 1'b0;
        reset     = 1'b1;
        clear_mon();
        @(posedge clk);
        #1;
        do_reset();

        check("reset_strobes", int'(strb), 0);
        check("reset_count8", int'(count8), 0);
        check("reset_count2", int'(count2), 0);

        // Table: hold 20 cycles, strobe expected after edge 7, never repeated.
        foreach (vecs[v]) begin
            clear_mon();
            key_n  = vecs[v].key;
            enable = vecs[v].en;
            cycles(20);
            check({vecs[v].name, "_edge"}, first_edge, (vecs[v].exp_mask != 4'b0) ? 7 : -1);
            for (int i = 0; i < 4; i++)
                check({vecs[v].name, "_strobes"}, scnt[i], vecs[v].exp_mask[i] ? 1 : 0);
            check({vecs[v].name, "_count"}, int'(count8), vecs[v].exp_count);
            release_all(vecs[v].name, vecs[v].exp_count);
        end
        exp8 = 4;

        // Bounce on right: 2-cycle glitches must all be discarded.
        clear_mon();
        for (int k = 0; k < 5; k++) begin
            key_n = 4'b1011;
            cycles(2);
            key_n = 4'b1111;
            cycles(2);
        end
        check("bounce_quiet", total_strobes(), 0);
        clear_mon();
        key_n = 4'b1011;
        cycles(20);
        exp8++;
        check("bounce_edge", first_edge, 7);
        check("bounce_r", scnt[2], 1);
        check("bounce_total", total_strobes(), 1);
        check("bounce_count", int'(count8), exp8);
        release_all("bounce", exp8);

        // Forward pressed while left is held is ignored until a fresh press.
        clear_mon();
        key_n = 4'b0111;
        cycles(7);
        exp8++;
        check("overlap_l_edge", first_edge, 7);
        cycles(5);
        key_n = 4'b0101;
        cycles(10);
        key_n = 4'b0111;
        cycles(8);
        check("overlap_no_f", scnt[1], 0);
        check("overlap_l_once", scnt[3], 1);
        check("overlap_count", int'(count8), exp8);
        release_all("overlap", exp8);
        clear_mon();
        key_n = 4'b1101;
        cycles(12);
        exp8++;
        check("fresh_f_edge", first_edge, 7);
        check("fresh_f", scnt[1], 1);
        check("fresh_count", int'(count8), exp8);
        release_all("fresh", exp8);

        // Saturation of the 2-bit counter, then clear racing a strobe.
        do_reset();
        check("sat_reset_count", int'(count2), 0);
        for (int p = 1; p <= 5; p++) begin
            clear_mon();
            key_n = 4'b0111;
            cycles(12);
            check("sat_strobe", scnt[3], 1);
            check("sat_count2", int'(count2), (p < 3) ? p : 3);
            check("sat_count8", int'(count8), p);
            release_all("sat", p);
        end
        clear_mon();
        key_n = 4'b0111;
        cycles(6);
        round_win = 1'b1;
        cycles(1);
        round_win = 1'b0;
        check("win_strobe_edge", first_edge, 7);
        check("win_strobe_l", scnt[3], 1);
        check("win_count2", int'(count2), 0);
        check("win_count8", int'(count8), 0);
        cycles(5);

        // Reset while the key is still held: one fresh strobe after release.
        reset = 1'b1;
        cycles(2);
        check("midreset_strobes", int'(strb), 0);
        check("midreset_count", int'(count2), 0);
        reset = 1'b0;
        clear_mon();
        cycles(15);
        check("postreset_edge", first_edge, 7);
        check("postreset_l", scnt[3], 1);
        check("postreset_total", total_strobes(), 1);
        check("postreset_count2", int'(count2), 1);
        release_all("postreset", 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frog_move_ctrl.md
Name: frog_move_ctrl

Overview:
- Converts the four raw board push-buttons (KEY[3:0], active-low, asynchronous, bouncy) into clean one-cycle, mutually exclusive move strobes L, R, F, B.
- Those strobes feed every frog grid cell in the playfield.
- Also keeps a saturating per-round move counter for the score display.
- Sits between the board KEY pins and the grid-cell array, in the game top level.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronized key level must hold before it is accepted. Use ≥2; use 4 in simulation and 500000 on the board at 50 MHz.
- CNT_W, 8, width of move_count.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high
- key_n  input  4  raw KEY[3:0], active-low: [3]=left, [2]=right, [1]=forward, [0]=back
- enable  input  1  1 = moves allowed; 0 = game frozen (game over / between rounds)
- round_win  input  1  one-cycle strobe; clears move_count
- L  output  1  one-cycle left-move strobe
- R  output  1  one-cycle right-move strobe
- F  output  1  one-cycle forward-move strobe
- B  output  1  one-cycle back-move strobe
- move_count  output  CNT_W  moves accepted this round, saturating

Behaviour:
- Reset is synchronous and active-high on clk, and takes priority over everything.
- Reset values:
  - Synchronizer flops = 1 (released).
  - Debounced levels db[3:0] = 0.
  - Debounce counters = 0.
  - FSM = IDLE.
  - L = R = F = B = 0.
  - move_count = 0.
- Synchronizer: two flops per key; key_s[i] = ~sync2[i].
- Debounce, per key, evaluated every edge:
  - If key_s[i] == db[i]: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: db[i] <= key_s[i] and counter <= 0.
  - Else: counter++.
  - Any glitch shorter than DEBOUNCE_CYCLES is discarded.
- Edge detect: rise[i] = db[i] & ~db_q[i]. db_q resets to 0.
- FSM states:
  - IDLE:
    - Exactly one rise[i] with every other db bit 0, and enable=1 → register the strobe for key i; go to HOLD.
    - Same condition with enable=0 → no strobe; go to HOLD.
    - Any rise while another db bit is 1, or two or more rises in the same cycle → no strobe; go to HOLD.
  - HOLD: stay until db == 4'b0000 is seen for one cycle, then go to IDLE. No strobe is ever emitted in HOLD. A second key pressed while one is held is ignored until all keys are released and a fresh press occurs.
- Strobe outputs:
  - Registered, at most one high per cycle, each high for exactly one cycle per accepted press.
  - Holding a key does not repeat.
- Latency: the strobe is high during the cycle after the (DEBOUNCE_CYCLES+3)-th rising edge that samples key_n[i] low, provided the level is stable throughout. For D=4 this is the 7th edge.
- move_count:
  - Increments in the same edge that registers a strobe.
  - Saturates at 2^CNT_W-1.
  - round_win=1 clears it to 0. Clear beats increment; the strobe is still emitted.
- Reset mid-press: everything returns to reset values. A key still held after reset is re-debounced and produces exactly one strobe.
- enable only gates strobe and count generation. Synchronizer, debounce and FSM keep running.

Decomposition:
- frog_pkg holds:
  - typedef enum logic {IDLE, HOLD} move_state_t.
  - Key index constants KEY_L=3, KEY_R=2, KEY_F=1, KEY_B=0.
- Sub-module key_debounce (parameter DEBOUNCE_CYCLES; ports clk, reset, key_n, level) contains the synchronizer and counter for one key. It is instantiated 4× via generate.
- The FSM, edge detect and counter stay in frog_move_ctrl.

Test Plan:
1. D=4. After reset, drive key_n=4'b0111 (left) steady for 20 cycles → L=1 for exactly one cycle after the 7th edge. R, F, B stay 0. move_count=1. No further strobe while held.
2. key_n[2] toggles low/high every 2 cycles for 10 cycles (bounce), then stays low → no strobe during the bounce. Exactly one R strobe 7 edges after the final fall. move_count increments by 1.
3. Hold left; 5 cycles after the L strobe also press forward, then release forward → no F strobe. Release all for 10 cycles, then press forward → one F strobe.
4. key_n=4'b1100 driven on the same edge → no strobe. After release, a single B press gives one B strobe.
5. enable=0, press right → no strobe, count unchanged. Release, set enable=1, press right → one R strobe.
6. CNT_W=2. Perform 5 presses → move_count sequence 1,2,3,3,3. round_win on the same cycle as the 6th strobe → strobe emitted, move_count=0. Assert reset while key held → outputs 0, then one strobe 7 edges after reset deasserts.
